// File: rtl/dtm_jtag_pkg.sv
// Shared debug definitions for the JTAG DTM: IR codes, DMI op codes,
// DTMCS / DMI scan field positions and the TAP and request state encodings.
package dtm_jtag_pkg;

    typedef enum logic [3:0] {
        TAP_RESET    = 4'h0,
        TAP_IDLE     = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SHIFT_DR = 4'h4,
        TAP_EXIT1_DR = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EXIT2_DR = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'ha,
        TAP_SHIFT_IR = 4'hb,
        TAP_EXIT1_IR = 4'hc,
        TAP_PAUSE_IR = 4'hd,
        TAP_EXIT2_IR = 4'he,
        TAP_UPD_IR   = 4'hf
    } tap_state_t;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_REQ  = 2'd1,
        REQ_RESP = 2'd2
    } req_state_t;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1f;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_BUSY  = 2'd3;

    localparam int DTMCS_VERSION_LSB = 0;
    localparam int DTMCS_VERSION_MSB = 3;
    localparam int DTMCS_ABITS_LSB   = 4;
    localparam int DTMCS_ABITS_MSB   = 9;
    localparam int DTMCS_DMISTAT_LSB = 10;
    localparam int DTMCS_DMISTAT_MSB = 11;
    localparam int DTMCS_IDLE_LSB    = 12;
    localparam int DTMCS_IDLE_MSB    = 14;
    localparam int DTMCS_DMIRESET    = 16;
    localparam int DTMCS_DMIHARDRESET = 17;

    localparam int DMI_OP_LSB   = 0;
    localparam int DMI_OP_MSB   = 1;
    localparam int DMI_DATA_LSB = 2;
    localparam int DMI_DATA_MSB = 33;
    localparam int DMI_ADDR_LSB = 34;
    localparam int DMI_ADDR_MSB = 40;
    localparam int DMI_LEN      = 41;

    function automatic logic [31:0] dtmcs_capture(input logic [1:0] dmistat);
        logic [31:0] v;
        v = '0;
        v[DTMCS_VERSION_MSB:DTMCS_VERSION_LSB] = 4'd1;
        v[DTMCS_ABITS_MSB:DTMCS_ABITS_LSB]     = 6'd7;
        v[DTMCS_DMISTAT_MSB:DTMCS_DMISTAT_LSB] = dmistat;
        v[DTMCS_IDLE_MSB:DTMCS_IDLE_LSB]       = 3'd1;
        return v;
    endfunction

endpackage

// File: rtl/dtm_jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller stepped by a synchronized tck-rise pulse;
// emits single-cycle capture/shift/update strobes for the state being left.
module jtag_tap_fsm
    import dtm_jtag_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic force_reset,
    input  logic tck_rise,
    input  logic tms,
    output logic test_logic_reset,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic in_shift_dr,
    output logic in_shift_ir
);

    tap_state_t state;
    tap_state_t state_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= TAP_RESET;
        end else if (force_reset) begin
            state <= TAP_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tck_rise) begin
            case (state)
                TAP_RESET:    state_next = tms ? TAP_RESET    : TAP_IDLE;
                TAP_IDLE:     state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
                TAP_SEL_DR:   state_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: state_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_next = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: state_next = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
                TAP_SEL_IR:   state_next = tms ? TAP_RESET    : TAP_CAP_IR;
                TAP_CAP_IR:   state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: state_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_next = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: state_next = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
                default:      state_next = TAP_RESET;
            endcase
        end
    end

    // Actions fire on the tck rise that leaves the named state.
    assign capture_dr = tck_rise && (state == TAP_CAP_DR);
    assign shift_dr   = tck_rise && (state == TAP_SHIFT_DR);
    assign update_dr  = tck_rise && (state == TAP_UPD_DR);
    assign capture_ir = tck_rise && (state == TAP_CAP_IR);
    assign shift_ir   = tck_rise && (state == TAP_SHIFT_IR);
    assign update_ir  = tck_rise && (state == TAP_UPD_IR);

    assign in_shift_dr      = (state == TAP_SHIFT_DR);
    assign in_shift_ir      = (state == TAP_SHIFT_IR);
    assign test_logic_reset = (state == TAP_RESET) || force_reset;

endmodule

// File: rtl/dtm_jtag.sv
// JTAG Debug Transport Module: turns DMI register scans into dmi_* requests.
// Define JTAG_TRST_EN to add the active-low trstn TAP reset input.
module dtm_jtag
    import dtm_jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE = 32'h10e31913,
    parameter int          ABITS  = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
`ifdef JTAG_TRST_EN
    input  logic             trstn,
`endif
    output logic             tdo,
    output logic             tdo_oe,
    output logic             dmi_valid,
    input  logic             dmi_ready,
    output logic             dmi_write,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata
);

    logic [2:0]  tck_sync;
    logic [1:0]  tms_sync;
    logic [1:0]  tdi_sync;
    logic        tck_rise;
    logic        tck_fall;
    logic        tap_force;

    logic        test_logic_reset;
    logic        capture_dr, shift_dr, update_dr;
    logic        capture_ir, shift_ir, update_ir;
    logic        in_shift_dr, in_shift_ir;

    logic [4:0]  ir;
    logic [4:0]  ir_sr;
    logic [DMI_LEN-1:0] dr_sr;
    logic [1:0]  sticky;
    logic        discard;
    logic [31:0] result_data;
    logic        dmi_start;
    logic [1:0]  scan_op;

    req_state_t  req_state;
    req_state_t  req_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
        end else begin
            tck_sync <= {tck_sync[1:0], tck};
            tms_sync <= {tms_sync[0], tms};
            tdi_sync <= {tdi_sync[0], tdi};
        end
    end

    assign tck_rise = tck_sync[1] & ~tck_sync[2];
    assign tck_fall = ~tck_sync[1] & tck_sync[2];

`ifdef JTAG_TRST_EN
    logic [1:0] trst_sync;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            trst_sync <= 2'b11;
        end else begin
            trst_sync <= {trst_sync[0], trstn};
        end
    end

    assign tap_force = ~trst_sync[1];
`else
    assign tap_force = 1'b0;
`endif

    jtag_tap_fsm u_tap (
        .clk              (clk),
        .resetn           (resetn),
        .force_reset      (tap_force),
        .tck_rise         (tck_rise),
        .tms              (tms_sync[1]),
        .test_logic_reset (test_logic_reset),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .capture_ir       (capture_ir),
        .shift_ir         (shift_ir),
        .update_ir        (update_ir),
        .in_shift_dr      (in_shift_dr),
        .in_shift_ir      (in_shift_ir)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ir    <= IR_IDCODE;
            ir_sr <= '0;
        end else if (test_logic_reset) begin
            ir <= IR_IDCODE;
        end else begin
            if (capture_ir) begin
                ir_sr <= 5'b00001;
            end else if (shift_ir) begin
                ir_sr <= {tdi_sync[1], ir_sr[4:1]};
            end
            if (update_ir) begin
                ir <= ir_sr;
            end
        end
    end

    assign scan_op   = dr_sr[DMI_OP_MSB:DMI_OP_LSB];
    assign dmi_start = update_dr && (ir == IR_DMI) && (req_state == REQ_IDLE) &&
                       (sticky == OP_NOP) && ((scan_op == OP_READ) || (scan_op == OP_WRITE));

    // DR shift register: 32-bit registers shift into bit 31, BYPASS into bit 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dr_sr   <= '0;
            sticky  <= OP_NOP;
            discard <= 1'b0;
        end else begin
            if (capture_dr) begin
                case (ir)
                    IR_IDCODE: dr_sr <= {9'b0, IDCODE};
                    IR_DTMCS:  dr_sr <= {9'b0, dtmcs_capture(sticky)};
                    IR_DMI: begin
                        if (req_state != REQ_IDLE) begin
                            dr_sr  <= {dmi_addr, result_data, OP_BUSY};
                            sticky <= OP_BUSY;
                        end else begin
                            dr_sr <= {dmi_addr, result_data, sticky};
                        end
                    end
                    default:   dr_sr <= '0;
                endcase
            end else if (shift_dr) begin
                case (ir)
                    IR_IDCODE, IR_DTMCS: dr_sr <= {9'b0, tdi_sync[1], dr_sr[31:1]};
                    IR_DMI:              dr_sr <= {tdi_sync[1], dr_sr[DMI_LEN-1:1]};
                    default:             dr_sr <= {40'b0, tdi_sync[1]};
                endcase
            end

            if (update_dr && (ir == IR_DTMCS)) begin
                if (dr_sr[DTMCS_DMIRESET] || dr_sr[DTMCS_DMIHARDRESET]) begin
                    sticky <= OP_NOP;
                end
                if (dr_sr[DTMCS_DMIHARDRESET] && (req_state != REQ_IDLE)) begin
                    discard <= 1'b1;
                end
            end
            // Completion clears discard so a late hard reset cannot poison the next request.
            if (req_state == REQ_RESP) begin
                discard <= 1'b0;
            end
            if (test_logic_reset) begin
                sticky <= OP_NOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_state <= REQ_IDLE;
        end else begin
            req_state <= req_next;
        end
    end

    always_comb begin
        req_next = req_state;
        case (req_state)
            REQ_IDLE: if (dmi_start) req_next = REQ_REQ;
            REQ_REQ:  if (dmi_ready) req_next = REQ_RESP;
            REQ_RESP: req_next = REQ_IDLE;
            default:  req_next = REQ_IDLE;
        endcase
    end

    assign dmi_valid = (req_state == REQ_REQ);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dmi_write   <= 1'b0;
            dmi_addr    <= '0;
            dmi_wdata   <= '0;
            result_data <= '0;
        end else begin
            if (dmi_start) begin
                dmi_write <= (scan_op == OP_WRITE);
                dmi_addr  <= dr_sr[DMI_ADDR_MSB:DMI_ADDR_LSB];
                dmi_wdata <= dr_sr[DMI_DATA_MSB:DMI_DATA_LSB];
            end
            if ((req_state == REQ_RESP) && !dmi_write && !discard) begin
                result_data <= dmi_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo_oe <= in_shift_dr | in_shift_ir;
            if (tck_fall) begin
                tdo <= in_shift_ir ? ir_sr[0] : dr_sr[0];
            end
        end
    end

endmodule

// File: tb/tb_dtm_jtag.sv
// Self-checking bench for dtm_jtag: bit-banged JTAG scans plus a DM stub,
// with scan captures and DMI requests checked against scoreboard queues.
module tb_dtm_jtag;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tck = 1'b0;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
`ifdef JTAG_TRST_EN
    logic        trstn = 1'b1;
`endif
    logic        tdo;
    logic        tdo_oe;
    logic        dmi_valid;
    logic        dmi_ready = 1'b0;
    logic        dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata = 32'h0;

    logic        hold_ready = 1'b0;
    logic        seen = 1'b0;
    logic [31:0] stub_rdata = 32'h0;

    logic [40:0] scan_q[$];
    logic [39:0] req_q[$];

    int n_asserts = 0;
    int n_fail = 0;

    dtm_jtag dut (
        .clk       (clk),
        .resetn    (resetn),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
`ifdef JTAG_TRST_EN
        .trstn     (trstn),
`endif
        .tdo       (tdo),
        .tdo_oe    (tdo_oe),
        .dmi_valid (dmi_valid),
        .dmi_ready (dmi_ready),
        .dmi_write (dmi_write),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_rdata (dmi_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DM stub: ready one cycle after valid is seen, read data the cycle after the handshake.
    always @(negedge clk) begin
        if (!resetn) begin
            dmi_ready = 1'b0;
            seen = 1'b0;
        end else if (dmi_ready) begin
            dmi_ready = 1'b0;
            dmi_rdata = stub_rdata;
            check("valid_after_hs", 64'(dmi_valid), 64'd0);
        end else if (dmi_valid && !hold_ready) begin
            if (seen) begin
                dmi_ready = 1'b1;
                seen = 1'b0;
                if (req_q.size() == 0) check("unexpected_req", 64'd1, 64'd0);
                else check("dmi_req", 64'({dmi_write, dmi_addr, dmi_wdata}), 64'(req_q.pop_front()));
            end else begin
                seen = 1'b1;
            end
        end
    end

    function automatic logic [40:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {a, d, op};
    endfunction

    task automatic tck_bit(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tdo_v = tdo;
        tms = tms_v;
        tdi = tdi_v;
        repeat (4) @(negedge clk);
        tck = 1'b1;
        repeat (4) @(negedge clk);
        tck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ir_scan(input logic [4:0] v);
        logic       b;
        logic [4:0] cap;
        cap = '0;
        tck_bit(1'b1, 1'b0, b);
        tck_bit(1'b1, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_bit(i == 4, v[i], b);
            cap[i] = b;
        end
        tck_bit(1'b1, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        check("ir_capture", 64'(cap), 64'd1);
    endtask

    task automatic dr_scan(input int n, input logic [40:0] din, output logic [40:0] dout);
        logic b;
        dout = '0;
        tck_bit(1'b1, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            if (i == 0) check("tdo_oe_shift", 64'(tdo_oe), 64'd1);
            tck_bit(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tck_bit(1'b1, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
    endtask

    task automatic scan_check(input int n, input logic [40:0] din, input logic [40:0] exp, input string tag);
        logic [40:0] got;
        scan_q.push_back(exp);
        dr_scan(n, din, got);
        check(tag, 64'(got), 64'(scan_q.pop_front()));
    endtask

    task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                            input logic [40:0] exp_cap, input logic issue, input string tag);
        if (issue) req_q.push_back({op == 2'd2, a, d});
        scan_check(41, dmi_word(a, d, op), exp_cap, tag);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic b;
        int   wait_cnt;
        repeat (4) @(negedge clk);
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_tdo_oe", 64'(tdo_oe), 64'd0);
        check("rst_valid", 64'(dmi_valid), 64'd0);
        check("rst_write", 64'(dmi_write), 64'd0);
        check("rst_addr", 64'(dmi_addr), 64'd0);
        check("rst_wdata", 64'(dmi_wdata), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        tck_bit(1'b0, 1'b0, b);
        scan_check(32, 41'h0, 41'h10e31913, "idcode");

        // Park IR on DTMCS, then five TMS=1 from Shift-DR must restore IDCODE.
        ir_scan(5'h10);
        tck_bit(1'b1, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) tck_bit(1'b1, 1'b0, b);
        tck_bit(1'b0, 1'b0, b);
        check("tdo_oe_idle", 64'(tdo_oe), 64'd0);
        scan_check(32, 41'h0, 41'h10e31913, "idcode_after_tlr");

        ir_scan(5'h10);
        scan_check(32, 41'h0, 41'h00001071, "dtmcs");

        ir_scan(5'h11);
        dmi_scan(7'h04, 32'hdeadbeef, 2'd2, dmi_word(7'h00, 32'h0, 2'd0), 1'b1, "dmi_first");
        repeat (10) @(negedge clk);
        stub_rdata = 32'h00400c82;
        dmi_scan(7'h11, 32'h0, 2'd1, dmi_word(7'h04, 32'h0, 2'd0), 1'b1, "dmi_after_write");
        repeat (10) @(negedge clk);
        dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h11, 32'h00400c82, 2'd0), 1'b0, "dmi_read_result");

        hold_ready = 1'b1;
        dmi_scan(7'h05, 32'h0, 2'd1, dmi_word(7'h11, 32'h00400c82, 2'd0), 1'b1, "dmi_busy_issue");
        repeat (10) @(negedge clk);
        check("valid_held", 64'(dmi_valid), 64'd1);
        dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h05, 32'h00400c82, 2'd3), 1'b0, "dmi_busy_capture");
        ir_scan(5'h10);
        scan_check(32, 41'h0, 41'h00001c71, "dtmcs_busy");
        ir_scan(5'h11);
        dmi_scan(7'h06, 32'h12345678, 2'd2, dmi_word(7'h05, 32'h00400c82, 2'd3), 1'b0, "dmi_busy_write");
        stub_rdata = 32'hcafef00d;
        hold_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("valid_released", 64'(dmi_valid), 64'd0);
        ir_scan(5'h10);
        scan_check(32, 41'h00010000, 41'h00001c71, "dtmcs_pre_clear");
        scan_check(32, 41'h0, 41'h00001071, "dtmcs_cleared");
        ir_scan(5'h11);
        dmi_scan(7'h07, 32'h0badf00d, 2'd2, dmi_word(7'h05, 32'hcafef00d, 2'd0), 1'b1, "dmi_after_clear");
        repeat (10) @(negedge clk);
        dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h07, 32'hcafef00d, 2'd0), 1'b0, "dmi_write_keeps_data");

        // Hard reset while a read is in flight drops its result.
        hold_ready = 1'b1;
        dmi_scan(7'h09, 32'h0, 2'd1, dmi_word(7'h07, 32'hcafef00d, 2'd0), 1'b1, "dmi_discard_issue");
        ir_scan(5'h10);
        scan_check(32, 41'h00020000, 41'h00001071, "dtmcs_hardreset");
        stub_rdata = 32'h11111111;
        hold_ready = 1'b0;
        repeat (10) @(negedge clk);
        ir_scan(5'h11);
        dmi_scan(7'h00, 32'h0, 2'd0, dmi_word(7'h09, 32'hcafef00d, 2'd0), 1'b0, "dmi_discarded");

        ir_scan(5'h1f);
        scan_check(8, 41'ha5, 41'h4a, "bypass");

        // resetn mid-transaction drops dmi_valid without a handshake.
        ir_scan(5'h11);
        hold_ready = 1'b1;
        dmi_scan(7'h0a, 32'h0, 2'd1, dmi_word(7'h09, 32'hcafef00d, 2'd0), 1'b0, "dmi_pre_reset");
        wait_cnt = 0;
        while (!dmi_valid && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("valid_before_reset", 64'(dmi_valid), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("valid_in_reset", 64'(dmi_valid), 64'd0);
        check("addr_in_reset", 64'(dmi_addr), 64'd0);
        resetn = 1'b1;
        hold_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("valid_after_reset", 64'(dmi_valid), 64'd0);
        tck_bit(1'b0, 1'b0, b);
        scan_check(32, 41'h0, 41'h10e31913, "idcode_after_reset");

        check("req_q_empty", 64'(req_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
